// File: rtl/apb_master_arbiter.sv
// rtl/apb_master_arbiter.sv - two-requester round-robin APB master with wait-state timeout
module apb_master_arbiter #(
   parameter int ADDR_W  = 8,
   parameter int DATA_W  = 8,
   parameter int TIMEOUT = 16
) (
   input  logic              i_Pclk,
   input  logic              i_Presetn,
   input  logic              i_Req0,
   input  logic              i_Req1,
   input  logic              i_Write0,
   input  logic              i_Write1,
   input  logic [ADDR_W-1:0] i_Addr0,
   input  logic [ADDR_W-1:0] i_Addr1,
   input  logic [DATA_W-1:0] i_Wdata0,
   input  logic [DATA_W-1:0] i_Wdata1,
   output logic              o_Done0,
   output logic              o_Done1,
   output logic              o_Err,
   output logic [DATA_W-1:0] o_Rdata,
   output logic              o_Psel,
   output logic              o_Penable,
   output logic              o_Pwrite,
   output logic [ADDR_W-1:0] o_Paddr,
   output logic [DATA_W-1:0] o_Pwdata,
   input  logic              i_Pready,
   input  logic [DATA_W-1:0] i_Prdata,
   input  logic              i_Pslverr
);

   localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

   typedef enum logic [1:0] {IDLE = 2'd0, SETUP = 2'd1, ACCESS = 2'd2} state_t;

   state_t          state;
   logic            ptr;
   logic            gnt;
   logic [CW-1:0]   cnt;
   logic            win;

   // Pointer only breaks ties; a lone requester always wins.
   assign win = (i_Req0 && i_Req1) ? ptr : i_Req1;

   always_ff @(posedge i_Pclk or negedge i_Presetn) begin
      if (!i_Presetn) begin
         state     <= IDLE;
         ptr       <= 1'b0;
         gnt       <= 1'b0;
         cnt       <= '0;
         o_Done0   <= 1'b0;
         o_Done1   <= 1'b0;
         o_Err     <= 1'b0;
         o_Rdata   <= '0;
         o_Psel    <= 1'b0;
         o_Penable <= 1'b0;
         o_Pwrite  <= 1'b0;
         o_Paddr   <= '0;
         o_Pwdata  <= '0;
      end else begin
         o_Done0 <= 1'b0;
         o_Done1 <= 1'b0;
         o_Err   <= 1'b0;
         case (state)
            IDLE: begin
               if (i_Req0 || i_Req1) begin
                  gnt      <= win;
                  o_Pwrite <= win ? i_Write1 : i_Write0;
                  o_Paddr  <= win ? i_Addr1  : i_Addr0;
                  o_Pwdata <= win ? i_Wdata1 : i_Wdata0;
                  o_Psel   <= 1'b1;
                  cnt      <= '0;
                  state    <= SETUP;
               end
            end
            SETUP: begin
               o_Penable <= 1'b1;
               state     <= ACCESS;
            end
            ACCESS: begin
               // Completion and timeout abort share the same teardown path.
               if (i_Pready || (cnt == CW'(TIMEOUT - 1))) begin
                  o_Psel    <= 1'b0;
                  o_Penable <= 1'b0;
                  o_Done0   <= ~gnt;
                  o_Done1   <= gnt;
                  o_Err     <= i_Pready ? i_Pslverr : 1'b1;
                  if (i_Pready && !o_Pwrite)
                     o_Rdata <= i_Prdata;
                  ptr       <= ~gnt;
                  state     <= IDLE;
               end else begin
                  cnt <= cnt + CW'(1);
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_apb_master_arbiter.sv
// tb/tb_apb_master_arbiter.sv - directed bench with a transaction-level reference model
module tb_apb_master_arbiter;
   localparam int TIMEOUT = 16;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       req0, req1, write0, write1;
   logic [7:0] addr0, addr1, wdata0, wdata1;
   logic       pready, pslverr;
   logic [7:0] prdata;
   logic       o_Done0, o_Done1, o_Err, o_Psel, o_Penable, o_Pwrite;
   logic [7:0] o_Rdata, o_Paddr, o_Pwdata;

   always #5 clk = ~clk;

   apb_master_arbiter #(.ADDR_W(8), .DATA_W(8), .TIMEOUT(TIMEOUT)) dut (
      .i_Pclk(clk), .i_Presetn(rst_n),
      .i_Req0(req0), .i_Req1(req1), .i_Write0(write0), .i_Write1(write1),
      .i_Addr0(addr0), .i_Addr1(addr1), .i_Wdata0(wdata0), .i_Wdata1(wdata1),
      .o_Done0(o_Done0), .o_Done1(o_Done1), .o_Err(o_Err), .o_Rdata(o_Rdata),
      .o_Psel(o_Psel), .o_Penable(o_Penable), .o_Pwrite(o_Pwrite),
      .o_Paddr(o_Paddr), .o_Pwdata(o_Pwdata),
      .i_Pready(pready), .i_Prdata(prdata), .i_Pslverr(pslverr)
   );

   int errors = 0;
   int checks = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: a transfer is "busy" from grant to completion; m_age counts
   // edges since grant (0 = setup cycle, k>=1 = k-th access cycle).
   logic       m_busy, m_gnt, m_ptr, m_write, m_done0, m_done1, m_err;
   logic [7:0] m_addr, m_wdata, m_rdata;
   int         m_age;
   logic       m_win;
   assign m_win = (req0 && req1) ? m_ptr : req1;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_busy <= 0; m_age <= 0; m_gnt <= 0; m_ptr <= 0; m_write <= 0;
         m_addr <= 0; m_wdata <= 0; m_done0 <= 0; m_done1 <= 0; m_err <= 0; m_rdata <= 0;
      end else begin
         m_done0 <= 0; m_done1 <= 0; m_err <= 0;
         if (!m_busy) begin
            if (req0 || req1) begin
               m_gnt   <= m_win;
               m_write <= m_win ? write1 : write0;
               m_addr  <= m_win ? addr1 : addr0;
               m_wdata <= m_win ? wdata1 : wdata0;
               m_busy  <= 1;
               m_age   <= 0;
            end
         end else if (m_age == 0) begin
            m_age <= 1;
         end else if (pready || m_age == TIMEOUT) begin
            m_busy <= 0;
            m_ptr  <= !m_gnt;
            if (m_gnt) m_done1 <= 1; else m_done0 <= 1;
            m_err  <= pready ? pslverr : 1'b1;
            if (pready && !m_write) m_rdata <= prdata;
         end else begin
            m_age <= m_age + 1;
         end
      end
   end

   always @(negedge clk) begin
      if (rst_n) begin
         chk("psel", o_Psel, m_busy);
         chk("penable", o_Penable, m_busy && m_age >= 1);
         chk("pwrite", o_Pwrite, m_write);
         chk("paddr", o_Paddr, m_addr);
         chk("pwdata", o_Pwdata, m_wdata);
         chk("done0", o_Done0, m_done0);
         chk("done1", o_Done1, m_done1);
         chk("err", o_Err, m_err);
         chk("rdata", o_Rdata, m_rdata);
         chk("done_excl", o_Done0 && o_Done1, 0);
      end
   end

   int         dn_who[$], dn_pen[$], dn_cyc[$];
   logic       dn_err[$];
   logic [7:0] dn_rdata[$];
   int         first_psel, first_pen;

   // Runs until n_done completions; slave inserts `waits` wait states per transfer.
   task automatic run(input int n_done, input int waits, input bit drop);
      int pen = 0;
      int got = 0;
      dn_who.delete(); dn_pen.delete(); dn_cyc.delete(); dn_err.delete(); dn_rdata.delete();
      first_psel = -1; first_pen = -1;
      for (int c = 1; c <= 200 && got < n_done; c++) begin
         @(negedge clk);
         if (o_Psel && first_psel < 0) first_psel = c;
         if (o_Penable && first_pen < 0) first_pen = c;
         if (o_Done0 || o_Done1) begin
            dn_who.push_back(o_Done1 ? 1 : 0);
            dn_err.push_back(o_Err);
            dn_rdata.push_back(o_Rdata);
            dn_pen.push_back(pen);
            dn_cyc.push_back(c);
            got++;
            pen = 0;
            if (drop) begin
               if (o_Done0) req0 = 0;
               if (o_Done1) req1 = 0;
            end
         end
         if (o_Penable) pen++;
         pready = o_Penable && (pen > waits);
      end
      pready = 0;
      chk("run_completions", got, n_done);
   endtask

   initial begin
      req0 = 0; req1 = 0; write0 = 0; write1 = 0;
      addr0 = 0; addr1 = 0; wdata0 = 0; wdata1 = 0;
      pready = 0; pslverr = 0; prdata = 0;
      repeat (3) @(negedge clk);
      chk("reset_psel", o_Psel, 0);
      chk("reset_penable", o_Penable, 0);
      chk("reset_done", {o_Done0, o_Done1, o_Err}, 0);
      chk("reset_rdata", o_Rdata, 0);
      rst_n = 1;

      // Single zero-wait write from requester 0
      @(negedge clk);
      req0 = 1; write0 = 1; addr0 = 8'h12; wdata0 = 8'hA5;
      run(1, 0, 1);
      chk("w_psel_lat", first_psel, 1);
      chk("w_pen_lat", first_pen, 2);
      chk("w_done_lat", dn_cyc[0], 3);
      chk("w_who", dn_who[0], 0);
      chk("w_err", dn_err[0], 0);
      chk("w_paddr", o_Paddr, 8'h12);
      chk("w_pwdata", o_Pwdata, 8'hA5);

      // Read from requester 1 with 5 wait states
      req1 = 1; write1 = 0; addr1 = 8'h40; prdata = 8'h3C;
      run(1, 5, 1);
      chk("r_who", dn_who[0], 1);
      chk("r_pen_cycles", dn_pen[0], 6);
      chk("r_rdata", dn_rdata[0], 8'h3C);
      chk("r_err", dn_err[0], 0);

      // Both held high: strict alternation with a one-cycle idle gap
      write0 = 1; write1 = 1; addr0 = 8'h01; addr1 = 8'h02; wdata0 = 8'h11; wdata1 = 8'h22;
      req0 = 1; req1 = 1;
      run(4, 0, 0);
      req0 = 0; req1 = 0;
      chk("rr_order", {dn_who[0][1:0], dn_who[1][1:0], dn_who[2][1:0], dn_who[3][1:0]}, 8'b00_01_00_01);
      chk("rr_spacing", dn_cyc[3] - dn_cyc[0], 9);

      // Stalled read from requester 0 aborts; pending requester 1 goes next
      @(negedge clk);
      prdata = 8'h99;
      req0 = 1; write0 = 0; addr0 = 8'h21;
      req1 = 1; write1 = 1; addr1 = 8'h31; wdata1 = 8'h5A;
      run(1, 1000, 1);
      chk("to_who", dn_who[0], 0);
      chk("to_pen_cycles", dn_pen[0], TIMEOUT);
      chk("to_err", dn_err[0], 1);
      chk("to_rdata_kept", dn_rdata[0], 8'h3C);
      chk("to_bus_idle", {o_Psel, o_Penable}, 0);
      run(1, 0, 1);
      chk("to_next_who", dn_who[0], 1);
      chk("to_next_err", dn_err[0], 0);

      // Slave error on a write, then a clean write
      pslverr = 1; req1 = 1; write1 = 1; addr1 = 8'h44; wdata1 = 8'hC3;
      run(1, 0, 1);
      chk("se_err", dn_err[0], 1);
      pslverr = 0; req0 = 1; write0 = 1; addr0 = 8'h45; wdata0 = 8'h3C;
      run(1, 0, 1);
      chk("se_clean_err", dn_err[0], 0);
      chk("se_clean_who", dn_who[0], 0);

      // Reset during ACCESS, pointer returns to requester 0
      @(negedge clk);
      req0 = 1; write0 = 0; addr0 = 8'h77; req1 = 1; write1 = 1; addr1 = 8'h78; wdata1 = 8'h0F;
      for (int c = 0; c < 20 && !o_Penable; c++) @(negedge clk);
      chk("rst_reached_access", o_Penable, 1);
      #2 rst_n = 0;
      #1;
      chk("rst_psel", o_Psel, 0);
      chk("rst_penable", o_Penable, 0);
      chk("rst_done", {o_Done0, o_Done1}, 0);
      @(negedge clk);
      rst_n = 1;
      prdata = 8'h6E;
      run(1, 0, 1);
      chk("rst_first_who", dn_who[0], 0);
      chk("rst_first_rdata", dn_rdata[0], 8'h6E);
      run(1, 0, 1);
      chk("rst_second_who", dn_who[0], 1);
      repeat (2) @(negedge clk);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/apb_master_arbiter.md
Name: apb_master_arbiter

Overview:
APB master-side controller that shares one APB port between two requesters (e.g. USRT TX and RX engines). It arbitrates round-robin, latches the winner's command, and sequences the IDLE -> SETUP -> ACCESS phases into the bus interface. It honours PREADY wait states and aborts stalled transfers after a programmable timeout. Completion status and read data go back to the granted requester.

Parameters:
ADDR_W, 8, width of i_Addr0/1 and o_Paddr
DATA_W, 8, width of write/read data buses
TIMEOUT, 16, maximum ACCESS cycles with PREADY low before the transfer is aborted (≥2)

Ports:
i_Pclk  in  1  APB clock; all state on rising edge
i_Presetn  in  1  asynchronous active-low reset
i_Req0 / i_Req1  in  1  level request; held high with operands stable until matching o_Done pulse
i_Write0 / i_Write1  in  1  1 = write, 0 = read
i_Addr0 / i_Addr1  in  ADDR_W  transfer address
i_Wdata0 / i_Wdata1  in  DATA_W  write data
o_Done0 / o_Done1  out  1  one-cycle completion pulse to that requester
o_Err  out  1  status for current o_Done pulse: PSLVERR or timeout
o_Rdata  out  DATA_W  read data, valid with o_Done of a read
o_Psel  out  1  APB PSEL
o_Penable  out  1  APB PENABLE
o_Pwrite  out  1  APB PWRITE
o_Paddr  out  ADDR_W  APB PADDR
o_Pwdata  out  DATA_W  APB PWDATA
i_Pready  in  1  APB PREADY
i_Prdata  in  DATA_W  APB PRDATA
i_Pslverr  in  1  APB PSLVERR

Behaviour:
- Reset (i_Presetn low, asynchronous): state IDLE; all outputs 0; round-robin pointer = requester 0; timeout counter 0. Reset mid-transfer drops o_Psel/o_Penable immediately; no o_Done is issued.
- All outputs registered.
- States: IDLE, SETUP, ACCESS.
- IDLE: if any i_ReqN high, grant one: only one high -> it wins; both high -> pointer-preferred wins. Latch i_WriteN/i_AddrN/i_WdataN into o_Pwrite/o_Paddr/o_Pwdata; next state SETUP. No request -> stay IDLE, o_Psel=0.
- SETUP (exactly 1 cycle): o_Psel=1, o_Penable=0; next ACCESS.
- ACCESS: o_Psel=1, o_Penable=1; o_Paddr/o_Pwrite/o_Pwdata held stable.
  - i_Pready=1: transfer completes this edge: pulse o_DoneN of granted requester next cycle; o_Err <= i_Pslverr; for reads, o_Rdata <= i_Prdata (writes leave o_Rdata unchanged); o_Psel, o_Penable <= 0; pointer <= other requester; state IDLE.
  - i_Pready=0: counter increments. When counter reaches TIMEOUT-1 with i_Pready still 0: abort — o_DoneN pulse with o_Err=1, o_Rdata unchanged, bus deasserted, pointer flips, state IDLE.
  - Counter cleared on entering SETUP.
- Minimum latency: request high in IDLE at edge N -> o_Psel at N+1, o_Penable at N+2, o_Done at N+3 with zero wait states.
- Every transfer returns to IDLE for at least 1 cycle; o_Psel is low ≥1 cycle between transfers. Requester must drop i_ReqN in the cycle o_DoneN is high; a request still high in the IDLE cycle after Done is treated as a new transfer.
- o_Err is meaningful only while an o_Done is high; it clears to 0 in all other cycles.
- Requests dropped before grant are ignored; operand changes after grant are ignored (latched copy used).
- Only one o_DoneN high at a time; never both.

Test Plan:
- Single write, req0: Addr=0x12, Wdata=0xA5, Pready=1 -> Psel at +1, Penable at +2, Done0 at +3, Err=0, Paddr=0x12, Pwdata=0xA5 throughout.
- Read with 5 wait states, req1: Pready low 5 ACCESS cycles then high with Prdata=0x3C -> Penable high 6 cycles, Done1 pulse, o_Rdata=0x3C, Err=0.
- Both requesters high continuously from reset -> grant order 0,1,0,1; Psel low 1 cycle between transfers; Done never concurrent.
- Pready held low, TIMEOUT=16 -> abort after 16 ACCESS cycles: Done0 with Err=1, o_Rdata unchanged, Psel/Penable 0, next grant goes to req1 if pending.
- Pslverr=1 with Pready=1 on a write -> Done with Err=1; next transfer with Pslverr=0 reports Err=0.
- Assert i_Presetn low during ACCESS -> Psel/Penable/Done 0 immediately; after release, pending req0 granted first (pointer reset).
